// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one single-port memory bank between NUM_CLIENTS requesters.
//
// Grants at most one request per cycle with round-robin priority. A client may hold
// exclusive ownership across several grants using req_lock. Bank strobes are registered,
// and read data is routed back to the issuing client through a one-hot tag pipeline.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   req_valid       per-client request pending (held until granted)
//   req_write       per-client 1 = write, 0 = read
//   req_width       per-client data_width code (0 = single, 1 = double)
//   req_lock        per-client keep ownership after the grant while asserted
//   req_addr        flattened per-client address, client i at [i*ADDR_W +: ADDR_W]
//   req_wdata       flattened per-client write data, client i at [i*DATA_W +: DATA_W]
//   req_ready       one-hot grant
//   mem_en          bank access strobe (read or write)
//   mem_chip_en     bank write enable
//   mem_data_width  registered width of the granted request
//   mem_addr        registered bank address
//   mem_wdata       registered bank write data
//   mem_rdata       bank read data, valid READ_LATENCY cycles after mem_en
//   rsp_valid       one-hot read-data-valid pulse
//   rsp_rdata       read data broadcast to all clients, qualified by rsp_valid
//   busy            a read is in flight or a lock is held
module mem_access_arbiter #(
  parameter int unsigned NUM_CLIENTS  = 4,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CLIENTS-1:0]        req_valid,
  input  logic [NUM_CLIENTS-1:0]        req_write,
  input  logic [NUM_CLIENTS-1:0]        req_width,
  input  logic [NUM_CLIENTS-1:0]        req_lock,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] req_wdata,
  output logic [NUM_CLIENTS-1:0]        req_ready,
  output logic                          mem_en,
  output logic                          mem_chip_en,
  output logic                          mem_data_width,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [NUM_CLIENTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          busy
);

  localparam int unsigned IdxW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  logic [IdxW-1:0]        rr_ptr_q;
  logic                   lock_held_q;
  logic [IdxW-1:0]        lock_owner_q;
  logic [NUM_CLIENTS-1:0] tag_q [READ_LATENCY+1];

  logic                   mem_en_q;
  logic                   mem_chip_en_q;
  logic                   mem_width_q;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic [DATA_W-1:0]      mem_wdata_q;

  logic                   lock_active;
  logic                   grant_any;
  logic [IdxW-1:0]        grant_idx;
  logic [IdxW-1:0]        cand;
  logic                   sel_write;
  logic                   sel_width;
  logic                   sel_lock;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic [NUM_CLIENTS-1:0] tag_or;

  // Grant selection. The lock only binds while the owner keeps both valid and lock high;
  // once it lets go, the same cycle falls back to round-robin, and since rr_ptr points at
  // the old owner it naturally gets lowest priority.
  always_comb begin
    lock_active = 1'b0;
    if (lock_held_q) begin
      lock_active = req_valid[lock_owner_q] & req_lock[lock_owner_q];
    end
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (lock_active) begin
      grant_any = 1'b1;
      grant_idx = lock_owner_q;
    end else begin
      for (int unsigned i = 1; i <= NUM_CLIENTS; i++) begin
        cand = IdxW'((32'(rr_ptr_q) + i) % NUM_CLIENTS);
        if (!grant_any && req_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
    req_ready = '0;
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Field mux for the granted client.
  always_comb begin
    sel_write = 1'b0;
    sel_width = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (grant_idx == IdxW'(i)) begin
        sel_write = req_write[i];
        sel_width = req_width[i];
        sel_lock  = req_lock[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= IdxW'(NUM_CLIENTS - 1);
      lock_held_q   <= 1'b0;
      lock_owner_q  <= '0;
      mem_en_q      <= 1'b0;
      mem_chip_en_q <= 1'b0;
      mem_width_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      for (int k = 0; k <= int'(READ_LATENCY); k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      mem_en_q      <= grant_any;
      mem_chip_en_q <= grant_any & sel_write;
      if (grant_any) begin
        rr_ptr_q    <= grant_idx;
        mem_width_q <= sel_width;
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
      end
      if (grant_any && sel_lock) begin
        lock_held_q  <= 1'b1;
        lock_owner_q <= grant_idx;
      end else if (!lock_active) begin
        lock_held_q  <= 1'b0;
      end
      // Only reads enter the tag pipeline; the last stage lines up with mem_rdata.
      tag_q[0] <= (grant_any && !sel_write) ? req_ready : '0;
      for (int k = 1; k <= int'(READ_LATENCY); k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  always_comb begin
    tag_or = '0;
    for (int k = 0; k <= int'(READ_LATENCY); k++) begin
      tag_or = tag_or | tag_q[k];
    end
  end

  assign mem_en         = mem_en_q;
  assign mem_chip_en    = mem_chip_en_q;
  assign mem_data_width = mem_width_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign rsp_valid      = tag_q[READ_LATENCY];
  assign rsp_rdata      = (|tag_q[READ_LATENCY]) ? mem_rdata : '0;
  assign busy           = (|tag_or) | lock_held_q;

endmodule
